board_switch_debounce: RTL and testbench
========================================

BOARD_SWITCH_DEBOUNCE -- requirements
Module: board_switch_debounce

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of the data bus and the ext_board_switch input.
REQ-002 The block SHALL have parameter SWITCH_WIDTH, default 10: number of active switch channels, 1..DATA_WIDTH.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: stability window in clocks, >=1.
REQ-004 The block SHALL have parameter COUNTER_WIDTH, default 16: per-channel counter width, with 2^COUNTER_WIDTH > DEBOUNCE_CYCLES.
REQ-005 The block SHALL have parameter EVENT_MODE, default 0: 0 = both edges, 1 = rising only, 2 = falling only.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port ext_board_switch, input, signed DATA_WIDTH: asynchronous switch pins; only bits [SWITCH_WIDTH-1:0] are used.
REQ-009 The block SHALL have port data, output, signed DATA_WIDTH: debounced levels in [SWITCH_WIDTH-1:0], upper bits 0.
REQ-010 The block SHALL have port rise, output, SWITCH_WIDTH: one-cycle pulse per channel on a debounced 0->1 change.
REQ-011 The block SHALL have port fall, output, SWITCH_WIDTH: one-cycle pulse per channel on a debounced 1->0 change.
REQ-012 The block SHALL have port event_flags, output, SWITCH_WIDTH: sticky per-channel event bits.
REQ-013 The block SHALL have port event_clear, input, SWITCH_WIDTH: write-one-to-clear mask for event_flags, sampled every cycle.
REQ-014 The block SHALL have port irq, output, 1 bit: OR-reduction of event_flags.

Function
REQ-015 Each channel SHALL pass through a two-flop synchronizer (s1, s2) before any other logic; no other logic SHALL read ext_board_switch.
REQ-016 The block SHALL run a two-state FSM: INIT (synchronizer fill, 2 cycles) and RUN.
REQ-017 In the last INIT cycle the block SHALL load stable <= s2 for every channel, clear the counters, emit no pulses or flags, and go to RUN.
REQ-018 In RUN with s2 == stable, the channel counter SHALL be cleared to 0.
REQ-019 In RUN with s2 != stable and counter < DEBOUNCE_CYCLES-1, the channel counter SHALL increment by 1.
REQ-020 In RUN with s2 != stable and counter == DEBOUNCE_CYCLES-1, the block SHALL set stable <= s2 and clear the counter on the same edge.
REQ-021 Latency: with a new level first sampled into s1 at edge E and held, data SHALL show the new level after edge E+DEBOUNCE_CYCLES+1.
REQ-022 Any glitch returning s2 to stable before the window completes SHALL reset the counter, leaving data, rise, fall and event_flags unchanged.
REQ-023 rise and fall SHALL be registered and asserted in the same cycle data changes, for exactly one cycle; otherwise 0.
REQ-024 event_flags[i] SHALL set on a debounced change of channel i qualified by EVENT_MODE.
REQ-025 event_flags[i] SHALL clear when event_clear[i]=1; when set and clear occur in the same cycle, set SHALL win.
REQ-026 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be reported in the same cycle.
REQ-027 Counters SHALL saturate and never wrap.

Reset
REQ-028 While reset=1 the block SHALL clear s1, s2, stable, counters, rise, fall and event_flags, drive data and irq to 0, and hold the FSM in INIT.
REQ-029 Assertion of reset at any time, including mid-window, SHALL abort debouncing; after release the block SHALL re-run INIT and adopt the pin levels without events.

Verification (DEBOUNCE_CYCLES=4, SWITCH_WIDTH=4, EVENT_MODE=0)
REQ-030 Scenario: pins=4'b0101 during and after reset -> data=16'h0005 after INIT, rise=fall=0, event_flags=0, irq=0.
REQ-031 Scenario: bit0 changes 0->1 sampled at edge E and held -> data[0]=1, rise=4'b0001 for one cycle after edge E+5, event_flags[0]=1, irq=1.
REQ-032 Scenario: bit1 high for 3 cycles then low -> no change on data, rise or event_flags.
REQ-033 Scenario: event_clear=4'b0001 issued in the same cycle a new bit0 event sets -> event_flags[0] stays 1; a clear in the following cycle -> 0, irq=0.
REQ-034 Scenario: reset pulsed after 2 cycles of a pending change -> no pulse; data equals the post-INIT pin level.
REQ-035 Scenario: EVENT_MODE=1, bit2 1->0 -> fall[2] pulses, event_flags[2] stays 0.

Source files
------------

// File: rtl/board_switch_debounce.sv
// Per-channel switch debouncer: two-flop synchronizer, stability counter,
// registered edge pulses and sticky, write-one-to-clear event flags with an interrupt.
module board_switch_debounce #(
  parameter int DATA_WIDTH      = 16,
  parameter int SWITCH_WIDTH    = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNTER_WIDTH   = 16,
  parameter int EVENT_MODE      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] ext_board_switch,
  output logic signed [DATA_WIDTH-1:0] data,
  output logic [SWITCH_WIDTH-1:0]      rise,
  output logic [SWITCH_WIDTH-1:0]      fall,
  output logic [SWITCH_WIDTH-1:0]      event_flags,
  input  logic [SWITCH_WIDTH-1:0]      event_clear,
  output logic                         irq
);

  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                    state;
  logic [1:0]                fill;
  logic [SWITCH_WIDTH-1:0]   s1;
  logic [SWITCH_WIDTH-1:0]   s2;
  logic [SWITCH_WIDTH-1:0]   stable;
  logic [SWITCH_WIDTH-1:0]   commit;
  logic [SWITCH_WIDTH-1:0]   rise_d;
  logic [SWITCH_WIDTH-1:0]   fall_d;
  logic [SWITCH_WIDTH-1:0]   set_d;
  logic [COUNTER_WIDTH-1:0]  cnt [SWITCH_WIDTH];

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c);
    return (c == '1) ? c : c + COUNTER_WIDTH'(1);
  endfunction

  function automatic logic [SWITCH_WIDTH-1:0] qualify(input logic [SWITCH_WIDTH-1:0] r,
                                                      input logic [SWITCH_WIDTH-1:0] f);
    case (EVENT_MODE)
      1:       return r;
      2:       return f;
      default: return r | f;
    endcase
  endfunction

  // Upper pin bits are not channels; they are deliberately left unconnected.
  if (SWITCH_WIDTH < DATA_WIDTH) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^ext_board_switch[DATA_WIDTH-1:SWITCH_WIDTH];
  end

  always_comb begin
    commit = '0;
    for (int i = 0; i < SWITCH_WIDTH; i++) begin
      commit[i] = (state == RUN) && (s2[i] != stable[i]) && (cnt[i] >= LAST);
    end
    rise_d = commit & s2;
    fall_d = commit & ~s2;
    set_d  = qualify(rise_d, fall_d);
  end

  always_comb begin
    data = '0;
    data[SWITCH_WIDTH-1:0] = stable;
  end

  assign irq = |event_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      fill        <= '0;
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      rise        <= '0;
      fall        <= '0;
      event_flags <= '0;
      for (int i = 0; i < SWITCH_WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1          <= ext_board_switch[SWITCH_WIDTH-1:0];
      s2          <= s1;
      rise        <= rise_d;
      fall        <= fall_d;
      // A new event in the same cycle as its clear keeps the flag set.
      event_flags <= (event_flags & ~event_clear) | set_d;
      case (state)
        INIT: begin
          for (int i = 0; i < SWITCH_WIDTH; i++) cnt[i] <= '0;
          fill <= fill + 2'd1;
          // Adopt the pin levels once both synchronizer stages hold them.
          if (fill == 2'd2) begin
            stable <= s2;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < SWITCH_WIDTH; i++) begin
            if (s2[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (commit[i]) begin
              stable[i] <= s2[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= sat_inc(cnt[i]);
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_board_switch_debounce.sv
// Directed bench for board_switch_debounce with a 4-cycle window, 4 channels;
// a second instance runs with rising-edge-only event qualification.
module tb_board_switch_debounce;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] pins;
  logic [3:0]         clr;
  logic signed [15:0] data0, data1;
  logic [3:0]         rise0, fall0, flags0, rise1, fall1, flags1;
  logic               irq0, irq1;
  int                 tests = 0;
  int                 fails = 0;

  board_switch_debounce #(
    .DATA_WIDTH(16), .SWITCH_WIDTH(4), .DEBOUNCE_CYCLES(4), .COUNTER_WIDTH(4), .EVENT_MODE(0)
  ) dut (
    .clk(clk), .reset(reset), .ext_board_switch(pins), .data(data0), .rise(rise0),
    .fall(fall0), .event_flags(flags0), .event_clear(clr), .irq(irq0)
  );

  board_switch_debounce #(
    .DATA_WIDTH(16), .SWITCH_WIDTH(4), .DEBOUNCE_CYCLES(4), .COUNTER_WIDTH(4), .EVENT_MODE(1)
  ) dut_rise (
    .clk(clk), .reset(reset), .ext_board_switch(pins), .data(data1), .rise(rise1),
    .fall(fall1), .event_flags(flags1), .event_clear(clr), .irq(irq1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  // Upper pin bits carry junk; they must never reach data.
  task automatic set_pins(input logic [3:0] v);
    pins = {12'hABC, v};
  endtask

  task automatic clear_all();
    clr = 4'hF;
    tick();
    clr = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr   = 4'h0;
    set_pins(4'b0101);
    tick_n(3);
    tests++; if (data0 !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", data0); end
    tests++; if (irq0 !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq0); end
    tests++; if (flags0 !== 4'h0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", flags0); end
    reset = 1'b0;
    tick_n(2);
    tests++; if (data0 !== 16'h0000) begin fails++; $display("FAIL init_hold: got %h expected 0000", data0); end
    tick();
    tests++; if (data0 !== 16'h0005) begin fails++; $display("FAIL init_adopt: got %h expected 0005", data0); end
    tick_n(3);
    tests++; if (data0 !== 16'h0005) begin fails++; $display("FAIL post_init_data: got %h expected 0005", data0); end
    tests++; if ((rise0 | fall0) !== 4'h0) begin fails++; $display("FAIL post_init_pulse: got %b/%b expected 0", rise0, fall0); end
    tests++; if (flags0 !== 4'h0 || irq0 !== 1'b0) begin fails++; $display("FAIL post_init_flags: got %b irq %b expected 0", flags0, irq0); end
  endtask

  task automatic test_fall_edge();
    set_pins(4'b0100);
    tick_n(5);
    tests++; if (data0 !== 16'h0005) begin fails++; $display("FAIL fall_latency: got %h expected 0005", data0); end
    tick();
    tests++; if (data0 !== 16'h0004) begin fails++; $display("FAIL fall_data: got %h expected 0004", data0); end
    tests++; if (fall0 !== 4'b0001 || rise0 !== 4'b0000) begin fails++; $display("FAIL fall_pulse: got fall %b rise %b expected 0001/0000", fall0, rise0); end
    tests++; if (flags0 !== 4'b0001 || irq0 !== 1'b1) begin fails++; $display("FAIL fall_flag: got %b irq %b expected 0001 1", flags0, irq0); end
    tick();
    tests++; if (fall0 !== 4'b0000) begin fails++; $display("FAIL fall_one_cycle: got %b expected 0000", fall0); end
    clear_all();
    tests++; if (flags0 !== 4'h0 || irq0 !== 1'b0) begin fails++; $display("FAIL fall_clear: got %b irq %b expected 0000 0", flags0, irq0); end
  endtask

  task automatic test_rise_edge();
    set_pins(4'b0101);
    tick_n(5);
    tests++; if (data0 !== 16'h0004) begin fails++; $display("FAIL rise_latency: got %h expected 0004", data0); end
    tick();
    tests++; if (data0 !== 16'h0005 || rise0 !== 4'b0001) begin fails++; $display("FAIL rise_pulse: got data %h rise %b expected 0005 0001", data0, rise0); end
    tests++; if (flags0 !== 4'b0001 || irq0 !== 1'b1) begin fails++; $display("FAIL rise_flag: got %b irq %b expected 0001 1", flags0, irq0); end
    tick();
    tests++; if (rise0 !== 4'b0000) begin fails++; $display("FAIL rise_one_cycle: got %b expected 0000", rise0); end
    clear_all();
  endtask

  task automatic test_clear_collision();
    set_pins(4'b0100);
    tick_n(5);
    clr = 4'b0001;
    tick();
    tests++; if (fall0 !== 4'b0001) begin fails++; $display("FAIL collide_pulse: got %b expected 0001", fall0); end
    tests++; if (flags0 !== 4'b0001) begin fails++; $display("FAIL collide_set_wins: got %b expected 0001", flags0); end
    tick();
    clr = 4'b0000;
    tests++; if (flags0 !== 4'b0000 || irq0 !== 1'b0) begin fails++; $display("FAIL collide_clear: got %b irq %b expected 0000 0", flags0, irq0); end
  endtask

  task automatic test_glitch();
    set_pins(4'b0110);
    tick_n(3);
    set_pins(4'b0100);
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (data0 !== 16'h0004 || rise0 !== 4'h0 || flags0 !== 4'h0) begin
        fails++;
        $display("FAIL glitch_c%0d: got data %h rise %b flags %b expected 0004 0000 0000", i, data0, rise0, flags0);
      end
    end
  endtask

  task automatic test_min_window();
    set_pins(4'b0110);
    tick_n(4);
    set_pins(4'b0100);
    tick();
    tests++; if (data0 !== 16'h0004) begin fails++; $display("FAIL minwin_early: got %h expected 0004", data0); end
    tick();
    tests++; if (data0 !== 16'h0006 || rise0 !== 4'b0010) begin fails++; $display("FAIL minwin_rise: got data %h rise %b expected 0006 0010", data0, rise0); end
    tick_n(3);
    tests++; if (data0 !== 16'h0006) begin fails++; $display("FAIL minwin_hold: got %h expected 0006", data0); end
    tick();
    tests++; if (data0 !== 16'h0004 || fall0 !== 4'b0010) begin fails++; $display("FAIL minwin_fall: got data %h fall %b expected 0004 0010", data0, fall0); end
    clear_all();
  endtask

  task automatic test_back_to_back();
    set_pins(4'b1011);
    tick_n(6);
    tests++; if (data0 !== 16'h000B) begin fails++; $display("FAIL multi_data: got %h expected 000b", data0); end
    tests++; if (rise0 !== 4'b1011 || fall0 !== 4'b0100) begin fails++; $display("FAIL multi_pulse: got rise %b fall %b expected 1011 0100", rise0, fall0); end
    tests++; if (flags0 !== 4'b1111) begin fails++; $display("FAIL multi_flags: got %b expected 1111", flags0); end
    tests++; if (flags1 !== 4'b1011) begin fails++; $display("FAIL multi_rise_only_flags: got %b expected 1011", flags1); end
    clear_all();
  endtask

  task automatic test_mode_rise();
    set_pins(4'b1111);
    tick_n(7);
    clear_all();
    set_pins(4'b1011);
    tick_n(6);
    tests++; if (fall1 !== 4'b0100 || data1 !== 16'h000B) begin fails++; $display("FAIL mode1_fall: got fall %b data %h expected 0100 000b", fall1, data1); end
    tests++; if (flags1 !== 4'b0000 || irq1 !== 1'b0) begin fails++; $display("FAIL mode1_no_flag: got %b irq %b expected 0000 0", flags1, irq1); end
    tests++; if (flags0 !== 4'b0100) begin fails++; $display("FAIL mode0_flag: got %b expected 0100", flags0); end
  endtask

  task automatic test_reset_mid();
    set_pins(4'b0101);
    tick_n(3);
    reset = 1'b1;
    tick_n(2);
    tests++; if (data0 !== 16'h0000 || (rise0 | fall0) !== 4'h0) begin fails++; $display("FAIL midrst_hold: got data %h rise %b fall %b expected 0000 0 0", data0, rise0, fall0); end
    reset = 1'b0;
    tick_n(3);
    tests++; if (data0 !== 16'h0005 || flags0 !== 4'h0) begin fails++; $display("FAIL midrst_adopt: got data %h flags %b expected 0005 0000", data0, flags0); end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (data0 !== 16'h0005 || (rise0 | fall0) !== 4'h0 || irq0 !== 1'b0) begin
        fails++;
        $display("FAIL midrst_quiet_c%0d: got data %h rise %b fall %b irq %b expected 0005 0 0 0", i, data0, rise0, fall0, irq0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_edge();
    test_rise_edge();
    test_clear_collision();
    test_glitch();
    test_min_window();
    test_back_to_back();
    test_mode_rise();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
